// File: rtl/paddle_ctrl.sv
// Pong paddle controller: manual up/down with speed ramp, auto ball tracking,
// travel clamped to [Y_MIN,Y_MAX], with freeze and recenter overrides.
module paddle_ctrl #(
  parameter int WIDTH       = 10,
  parameter int POS_X       = 20,
  parameter int POS_Y       = 200,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 280,
  parameter int PADDLE_H    = 200,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int AI_SPEED    = 2,
  parameter int DEAD_ZONE   = 4
) (
  input  logic             game_clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             auto_mode,
  input  logic [WIDTH-1:0] ball_y,
  input  logic             freeze,
  input  logic             recenter,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             moving,
  output logic             dir_down,
  output logic [3:0]       speed,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int W1    = WIDTH + 1;
  localparam int CNT_W = (ACCEL_TICKS > 2) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [W1-1:0]    Y_MIN_E  = W1'(Y_MIN);
  localparam logic [W1-1:0]    Y_MAX_E  = W1'(Y_MAX);
  localparam logic [W1-1:0]    HALF_H_E = W1'(PADDLE_H / 2);
  localparam logic [W1-1:0]    DZ_E     = W1'(DEAD_ZONE);
  localparam logic [3:0]       SPD_MIN  = 4'(SPEED_MIN);
  localparam logic [3:0]       SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [3:0]       SPD_AI   = 4'(AI_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       speed_q, speed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_down_q, dir_down_d;
  logic             mode_q, mode_d;

  state_t           req;
  logic             fresh;
  logic             hit;
  logic [3:0]       step;
  logic [W1-1:0]    y_ext, step_ext, centre, ball_ext;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    y_d        = y_q;
    speed_d    = speed_q;
    count_d    = count_q;
    dir_down_d = dir_down_q;
    mode_d     = mode_q;
    req        = IDLE;
    fresh      = 1'b0;
    hit        = 1'b0;
    step       = SPD_MIN;
    y_ext      = {1'b0, y_q};
    ball_ext   = {1'b0, ball_y};
    centre     = y_ext + HALF_H_E;
    step_ext   = '0;
    count_inc  = count_q + 1'b1;

    if (auto_mode) begin
      if (ball_ext + DZ_E < centre)      req = UP;
      else if (ball_ext > centre + DZ_E) req = DOWN;
    end else begin
      if (up && !down)      req = UP;
      else if (down && !up) req = DOWN;
    end

    if (recenter) begin
      y_d        = WIDTH'(POS_Y);
      state_d    = IDLE;
      speed_d    = SPD_MIN;
      count_d    = '0;
      dir_down_d = 1'b0;
      mode_d     = auto_mode;
    end else if (freeze) begin
      // hold everything, including the remembered mode
    end else if (auto_mode != mode_q) begin
      mode_d  = auto_mode;
      state_d = IDLE;
      speed_d = SPD_MIN;
      count_d = '0;
    end else if (req == IDLE) begin
      state_d = IDLE;
      speed_d = SPD_MIN;
      count_d = '0;
    end else begin
      // Entering motion or reversing always restarts the ramp at SPEED_MIN.
      fresh    = (state_q != req);
      step     = auto_mode ? SPD_AI : (fresh ? SPD_MIN : speed_q);
      step_ext = W1'(step);
      state_d  = req;
      dir_down_d = (req == DOWN);

      if (req == UP) begin
        if (y_ext < Y_MIN_E + step_ext) begin
          hit = 1'b1;
          y_d = WIDTH'(Y_MIN_E);
        end else begin
          y_d = WIDTH'(y_ext - step_ext);
        end
      end else begin
        if (y_ext + step_ext > Y_MAX_E) begin
          hit = 1'b1;
          y_d = WIDTH'(Y_MAX_E);
        end else begin
          y_d = WIDTH'(y_ext + step_ext);
        end
      end

      if (auto_mode || fresh || hit) begin
        speed_d = SPD_MIN;
        count_d = '0;
      end else if (count_inc == CNT_LAST) begin
        count_d = '0;
        speed_d = (speed_q < SPD_MAX) ? speed_q + 4'd1 : SPD_MAX;
      end else begin
        count_d = count_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge game_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      y_q        <= WIDTH'(POS_Y);
      speed_q    <= SPD_MIN;
      count_q    <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      speed_q    <= speed_d;
      count_q    <= count_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode_d;
    end
  end

  assign x         = WIDTH'(POS_X);
  assign y         = y_q;
  assign moving    = (state_q != IDLE);
  assign dir_down  = dir_down_q;
  assign speed     = speed_q;
  assign at_top    = (y_q == WIDTH'(Y_MIN));
  assign at_bottom = (y_q == WIDTH'(Y_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised and directed bench for paddle_ctrl against an integer model of
// the paddle rules (position, direction, speed ramp, clamping, overrides).
module tb_paddle_ctrl;

  localparam int WIDTH = 10, POS_X = 20, POS_Y = 200, Y_MIN = 0, Y_MAX = 280;
  localparam int PADDLE_H = 200, SPEED_MIN = 1, SPEED_MAX = 4, ACCEL_TICKS = 8;
  localparam int AI_SPEED = 2, DEAD_ZONE = 4;

  logic             game_clk = 1'b0;
  logic             rst_n;
  logic             up, down, auto_mode, freeze, recenter;
  logic [WIDTH-1:0] ball_y;
  logic [WIDTH-1:0] x, y;
  logic             moving, dir_down, at_top, at_bottom;
  logic [3:0]       speed;

  int errors = 0;
  int checks = 0;

  // Model state: direction is -1 (up), 0 (idle), +1 (down).
  int m_y, m_dir, m_speed, m_cnt, m_dd, m_mode;

  paddle_ctrl dut (
    .game_clk (game_clk),
    .rst_n    (rst_n),
    .up       (up),
    .down     (down),
    .auto_mode(auto_mode),
    .ball_y   (ball_y),
    .freeze   (freeze),
    .recenter (recenter),
    .x        (x),
    .y        (y),
    .moving   (moving),
    .dir_down (dir_down),
    .speed    (speed),
    .at_top   (at_top),
    .at_bottom(at_bottom)
  );

  always #5 game_clk = ~game_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = POS_Y; m_dir = 0; m_speed = SPEED_MIN; m_cnt = 0; m_dd = 0; m_mode = 0;
  endtask

  task automatic model_edge();
    int req, step, ny, c;
    bit fresh, hit;
    if (recenter) begin
      m_y = POS_Y; m_dir = 0; m_speed = SPEED_MIN; m_cnt = 0; m_dd = 0;
      m_mode = auto_mode;
    end else if (freeze) begin
      // paused
    end else if (int'(auto_mode) != m_mode) begin
      m_mode = auto_mode; m_dir = 0; m_speed = SPEED_MIN; m_cnt = 0;
    end else begin
      if (auto_mode) begin
        c = m_y + PADDLE_H / 2;
        req = (int'(ball_y) + DEAD_ZONE < c) ? -1 : (int'(ball_y) > c + DEAD_ZONE) ? 1 : 0;
      end else begin
        req = (up && !down) ? -1 : (down && !up) ? 1 : 0;
      end
      if (req == 0) begin
        m_dir = 0; m_speed = SPEED_MIN; m_cnt = 0;
      end else begin
        fresh = (m_dir != req);
        step  = auto_mode ? AI_SPEED : (fresh ? SPEED_MIN : m_speed);
        ny    = m_y + req * step;
        hit   = (ny < Y_MIN) || (ny > Y_MAX);
        if (ny < Y_MIN) ny = Y_MIN;
        if (ny > Y_MAX) ny = Y_MAX;
        if (auto_mode || fresh || hit) begin
          m_speed = SPEED_MIN; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == ACCEL_TICKS - 1) begin
            m_cnt = 0;
            if (m_speed < SPEED_MAX) m_speed++;
          end
        end
        m_y = ny; m_dir = req; m_dd = (req > 0);
      end
    end
  endtask

  task automatic compare_all();
    check("x", int'(x), POS_X);
    check("y", int'(y), m_y);
    check("moving", int'(moving), int'(m_dir != 0));
    check("dir_down", int'(dir_down), m_dd);
    check("speed", int'(speed), m_speed);
    check("at_top", int'(at_top), int'(m_y == Y_MIN));
    check("at_bottom", int'(at_bottom), int'(m_y == Y_MAX));
  endtask

  task automatic step_edge();
    @(posedge game_clk);
    #1;
    model_edge();
    compare_all();
  endtask

  // Asynchronous reset applied away from the clock edge and checked before the next one.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_y", int'(y), POS_Y);
    check("rst_x", int'(x), POS_X);
    check("rst_moving", int'(moving), 0);
    check("rst_speed", int'(speed), SPEED_MIN);
    check("rst_dir_down", int'(dir_down), 0);
    compare_all();
    rst_n = 1'b1;
  endtask

  int y_saved, spd_saved;

  initial begin
    up = 0; down = 0; auto_mode = 0; freeze = 0; recenter = 0; ball_y = '0;
    rst_n = 1'b1;
    #2;
    pulse_reset();

    // Manual ramp: 8 edges at step 1, then speed 2.
    up = 1;
    repeat (8) step_edge();
    check("hold8_y", int'(y), 192);
    step_edge();
    check("edge9_y", int'(y), 190);
    check("edge9_speed", int'(speed), 2);

    // Run into the top limit and keep pushing.
    repeat (60) step_edge();
    check("top_y", int'(y), Y_MIN);
    check("top_flag", int'(at_top), 1);
    check("top_speed", int'(speed), SPEED_MIN);
    repeat (3) step_edge();
    check("top_hold_y", int'(y), Y_MIN);

    // Both buttons: idle, no movement.
    down = 1;
    step_edge();
    check("both_moving", int'(moving), 0);
    check("both_y", int'(y), Y_MIN);

    // Reversal at speed 3 restarts at step 1.
    up = 0; down = 0; recenter = 1;
    step_edge();
    recenter = 0; up = 1;
    repeat (18) step_edge();
    check("pre_rev_speed", int'(speed), 3);
    y_saved = int'(y);
    up = 0; down = 1;
    step_edge();
    check("rev_y", int'(y), y_saved + 1);
    check("rev_dir_down", int'(dir_down), 1);

    // Freeze holds state; recenter overrides freeze.
    down = 0; up = 1;
    repeat (10) step_edge();
    y_saved = int'(y); spd_saved = int'(speed);
    freeze = 1;
    repeat (5) step_edge();
    check("freeze_y", int'(y), y_saved);
    check("freeze_speed", int'(speed), spd_saved);
    recenter = 1;
    step_edge();
    check("recenter_freeze_y", int'(y), POS_Y);
    recenter = 0; freeze = 0; up = 0;

    // Auto tracking toward ball_y=150 settles at 54; ball low clamps at bottom.
    auto_mode = 1; ball_y = 10'd150;
    repeat (100) step_edge();
    check("auto_y", int'(y), 54);
    check("auto_moving", int'(moving), 0);
    ball_y = 10'd479;
    repeat (200) step_edge();
    check("auto_bottom_y", int'(y), Y_MAX);
    check("auto_bottom_flag", int'(at_bottom), 1);

    // Reset while moving up.
    auto_mode = 0; up = 1;
    repeat (30) step_edge();
    check("pre_reset_moving", int'(moving), 1);
    pulse_reset();

    // Randomised phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        up = $urandom_range(0, 1); down = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 15) == 0) ball_y = WIDTH'($urandom_range(0, 479));
      freeze   = ($urandom_range(0, 9) == 0);
      recenter = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
